// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding and program-counter constants.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] PC_INC = 32'd4;
  localparam logic [INSTR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DELIVER = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read bus: req/addr from the fetch unit, ack/rdata back from memory.
interface instr_fetch_unit_if;
  import cpu_pkg::*;

  logic               mem_req;
  logic [INSTR_W-1:0] mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;

  modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// Program counter plus req/ack fetch FSM feeding the instruction register.
// Redirects during an outstanding request flush the returning word.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          INSTR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  input  logic               jump_taken,
  input  logic [INSTR_W-1:0] jump_target,
  input  logic               branch_taken,
  input  logic [INSTR_W-1:0] branch_target,
  instr_fetch_unit_if.master mem,
  output logic [INSTR_W-1:0] instruction,
  output logic               IRwrite,
  output logic [INSTR_W-1:0] pc,
  output logic [INSTR_W-1:0] pc_plus4,
  output logic               busy
);

  fetch_state_t       state;
  logic [INSTR_W-1:0] req_addr;
  logic               flush;
  logic               mem_req_q;
  logic               redir;
  logic [INSTR_W-1:0] redir_tgt_raw;
  logic [INSTR_W-1:0] redir_tgt;

  // Jump has priority; targets are forced word-aligned.
  assign redir         = jump_taken | branch_taken;
  assign redir_tgt_raw = jump_taken ? jump_target : branch_target;
  assign redir_tgt     = {redir_tgt_raw[INSTR_W-1:2], 2'b00};

  assign pc_plus4     = pc + INSTR_W'(PC_INC);
  assign busy         = (state != IDLE);
  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = req_addr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      pc          <= INSTR_W'(RESET_PC);
      req_addr    <= INSTR_W'(RESET_PC);
      instruction <= '0;
      IRwrite     <= 1'b0;
      mem_req_q   <= 1'b0;
      flush       <= 1'b0;
    end else begin
      IRwrite <= 1'b0;
      case (state)
        IDLE: begin
          if (redir) pc <= redir_tgt;
          if (fetch_en) begin
            req_addr  <= pc;
            mem_req_q <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (redir) pc <= redir_tgt;
          if (mem.mem_ack) begin
            mem_req_q <= 1'b0;
            if (flush || redir) begin
              flush <= 1'b0;
              state <= IDLE;
            end else begin
              instruction <= mem.mem_rdata;
              pc          <= pc_plus4;
              IRwrite     <= 1'b1;
              state       <= DELIVER;
            end
          end else if (redir) begin
            flush <= 1'b1;
          end
        end
        DELIVER: begin
          if (redir) pc <= redir_tgt;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: memory is played by the stimulus tasks.
module tb_instr_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en, jump_taken, branch_taken;
  logic [31:0] jump_target, branch_target;
  logic [31:0] instruction, pc, pc_plus4;
  logic        IRwrite, busy;
  int          checks = 0;
  int          errors = 0;

  instr_fetch_unit_if mif ();

  instr_fetch_unit #(.RESET_PC(32'h0), .INSTR_W(32)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .jump_taken(jump_taken), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .mem(mif), .instruction(instruction), .IRwrite(IRwrite),
    .pc(pc), .pc_plus4(pc_plus4), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; fetch_en = 1'b0; jump_taken = 1'b0; branch_taken = 1'b0;
    jump_target = '0; branch_target = '0;
    mif.mem_ack = 1'b0; mif.mem_rdata = '0;
    tick(); tick();
    rst = 1'b1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
    checks++; if (mif.mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", mif.mem_req); end
    checks++; if (IRwrite !== 1'b0) begin errors++; $display("FAIL reset_irw got %b exp 0", IRwrite); end
    checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", instruction); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_pcp4 got %h exp 4", pc_plus4); end
  endtask

  task automatic test_fetch();
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    checks++; if (mif.mem_req !== 1'b1 || mif.mem_addr !== 32'h0) begin errors++; $display("FAIL fetch_req got %b/%h exp 1/0", mif.mem_req, mif.mem_addr); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fetch_busy got %b exp 1", busy); end
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'h2008_0005;
    tick();
    mif.mem_ack = 1'b0;
    checks++; if (IRwrite !== 1'b1) begin errors++; $display("FAIL fetch_irw got %b exp 1", IRwrite); end
    checks++; if (instruction !== 32'h2008_0005) begin errors++; $display("FAIL fetch_instr got %h exp 20080005", instruction); end
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL fetch_pc got %h exp 4", pc); end
    checks++; if (mif.mem_req !== 1'b0) begin errors++; $display("FAIL fetch_req_drop got %b exp 0", mif.mem_req); end
    tick();
    checks++; if (IRwrite !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL fetch_idle got irw %b busy %b exp 0/0", IRwrite, busy); end
  endtask

  task automatic test_wait_states();
    int pulses = 0;
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (mif.mem_req !== 1'b1 || mif.mem_addr !== 32'h4) begin errors++; $display("FAIL wait_hold%0d got %b/%h exp 1/4", i, mif.mem_req, mif.mem_addr); end
      if (IRwrite) pulses++;
      if (i == 3) begin mif.mem_ack = 1'b1; mif.mem_rdata = 32'hAAAA_0001; end
      tick();
    end
    mif.mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (IRwrite) pulses++;
      tick();
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL wait_pulses got %0d exp 1", pulses); end
    checks++; if (instruction !== 32'hAAAA_0001 || pc !== 32'h8) begin errors++; $display("FAIL wait_result got %h/%h exp aaaa0001/8", instruction, pc); end
  endtask

  task automatic test_redirect_req();
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    checks++; if (mif.mem_addr !== 32'h8) begin errors++; $display("FAIL redir_addr got %h exp 8", mif.mem_addr); end
    jump_taken = 1'b1; jump_target = 32'h40;
    tick();
    jump_taken = 1'b0;
    checks++; if (pc !== 32'h40 || mif.mem_req !== 1'b1 || mif.mem_addr !== 32'h8) begin errors++; $display("FAIL redir_inflight got pc %h req %b addr %h exp 40/1/8", pc, mif.mem_req, mif.mem_addr); end
    // Second redirect while still waiting: pc overwritten, flush stays armed.
    branch_taken = 1'b1; branch_target = 32'h50;
    tick();
    branch_taken = 1'b0;
    checks++; if (pc !== 32'h50) begin errors++; $display("FAIL redir_second got %h exp 50", pc); end
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'hDEAD_BEEF;
    tick();
    mif.mem_ack = 1'b0;
    checks++; if (IRwrite !== 1'b0 || busy !== 1'b0 || mif.mem_req !== 1'b0) begin errors++; $display("FAIL redir_flush got irw %b busy %b req %b exp 0/0/0", IRwrite, busy, mif.mem_req); end
    checks++; if (instruction !== 32'hAAAA_0001 || pc !== 32'h50) begin errors++; $display("FAIL redir_keep got %h/%h exp aaaa0001/50", instruction, pc); end
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    checks++; if (mif.mem_addr !== 32'h50) begin errors++; $display("FAIL redir_newaddr got %h exp 50", mif.mem_addr); end
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'h1234_5678;
    tick();
    mif.mem_ack = 1'b0;
    checks++; if (IRwrite !== 1'b1 || instruction !== 32'h1234_5678 || pc !== 32'h54) begin errors++; $display("FAIL redir_refetch got %b/%h/%h exp 1/12345678/54", IRwrite, instruction, pc); end
    tick();
  endtask

  task automatic test_redirect_with_ack();
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    branch_taken = 1'b1; branch_target = 32'h81;
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'hBAD0_0000;
    tick();
    branch_taken = 1'b0; mif.mem_ack = 1'b0;
    checks++; if (IRwrite !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ackredir_state got irw %b busy %b exp 0/0", IRwrite, busy); end
    checks++; if (pc !== 32'h80 || instruction !== 32'h1234_5678) begin errors++; $display("FAIL ackredir_pc got %h/%h exp 80/12345678", pc, instruction); end
    tick();
    checks++; if (IRwrite !== 1'b0) begin errors++; $display("FAIL ackredir_late got %b exp 0", IRwrite); end
  endtask

  task automatic test_simultaneous();
    jump_taken = 1'b1; jump_target = 32'h103;
    branch_taken = 1'b1; branch_target = 32'h200;
    tick();
    jump_taken = 1'b0; branch_taken = 1'b0;
    checks++; if (pc !== 32'h100 || busy !== 1'b0) begin errors++; $display("FAIL simul_pc got %h busy %b exp 100/0", pc, busy); end
    branch_taken = 1'b1; branch_target = 32'h202;
    tick();
    branch_taken = 1'b0;
    checks++; if (pc !== 32'h200) begin errors++; $display("FAIL branch_align got %h exp 200", pc); end
    // Redirect in DELIVER replaces the incremented pc and starts nothing.
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'h0000_0013;
    tick();
    mif.mem_ack = 1'b0;
    checks++; if (pc !== 32'h204 || IRwrite !== 1'b1) begin errors++; $display("FAIL deliver_pre got %h/%b exp 204/1", pc, IRwrite); end
    jump_taken = 1'b1; jump_target = 32'h300;
    tick();
    jump_taken = 1'b0;
    checks++; if (pc !== 32'h300 || busy !== 1'b0 || IRwrite !== 1'b0) begin errors++; $display("FAIL deliver_redir got %h busy %b irw %b exp 300/0/0", pc, busy, IRwrite); end
    tick();
    checks++; if (mif.mem_req !== 1'b0) begin errors++; $display("FAIL deliver_nofetch got %b exp 0", mif.mem_req); end
  endtask

  task automatic test_wrap();
    jump_taken = 1'b1; jump_target = 32'hFFFF_FFFC;
    tick();
    jump_taken = 1'b0;
    checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_pcp4 got %h exp 0", pc_plus4); end
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    checks++; if (mif.mem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got %h exp fffffffc", mif.mem_addr); end
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'hCAFE_F00D;
    tick();
    mif.mem_ack = 1'b0;
    checks++; if (pc !== 32'h0 || instruction !== 32'hCAFE_F00D) begin errors++; $display("FAIL wrap_pc got %h/%h exp 0/cafef00d", pc, instruction); end
    tick();
  endtask

  task automatic test_reset_mid();
    jump_taken = 1'b1; jump_target = 32'h60;
    tick();
    jump_taken = 1'b0;
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    checks++; if (mif.mem_req !== 1'b1 || mif.mem_addr !== 32'h60) begin errors++; $display("FAIL rstmid_req got %b/%h exp 1/60", mif.mem_req, mif.mem_addr); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++; if (mif.mem_req !== 1'b0 || pc !== 32'h0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_state got req %b pc %h busy %b exp 0/0/0", mif.mem_req, pc, busy); end
    checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL rstmid_instr got %h exp 0", instruction); end
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'h7777_7777;
    tick();
    mif.mem_ack = 1'b0;
    checks++; if (IRwrite !== 1'b0 || busy !== 1'b0 || instruction !== 32'h0) begin errors++; $display("FAIL rstmid_lateack got irw %b busy %b instr %h exp 0/0/0", IRwrite, busy, instruction); end
    tick();
    checks++; if (IRwrite !== 1'b0 || pc !== 32'h0) begin errors++; $display("FAIL rstmid_after got irw %b pc %h exp 0/0", IRwrite, pc); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_wait_states();
    test_redirect_req();
    test_redirect_with_ack();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
